// File: rtl/decode_writeback_if.sv
// Fetch/execute/memory facing bundle for the SEQ decode + writeback block.
// Latency: pure wiring, none.
// Backpressure: none; wb_en qualifies each commit edge.
interface decode_writeback_if;
  // Stimulus from fetch / execute / memory
  logic        wb_en;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        OF;
  logic        ZF;
  logic        SF;
  logic [3:0]  dbg_addr;

  // Results back to execute / debug
  logic [63:0] valA;
  logic [63:0] valB;
  logic        Cnd;
  logic [2:0]  cc;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] dbg_data;

  modport master (
    output wb_en, icode, ifun, rA, rB, valE, valM, OF, ZF, SF, dbg_addr,
    input  valA, valB, Cnd, cc, dstE, dstM, dbg_data
  );

  modport slave (
    input  wb_en, icode, ifun, rA, rB, valE, valM, OF, ZF, SF, dbg_addr,
    output valA, valB, Cnd, cc, dstE, dstM, dbg_data
  );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 SEQ register file + condition codes with decode source/dest selection and writeback.
// Latency: valA/valB/Cnd/dst* combinational; register and CC writes visible after the commit edge.
// Backpressure: none; always accepts, commit gated by wb_en (reset overrides).
module decode_writeback #(
  parameter int         NREGS  = 15,
  parameter logic [3:0] RSP_ID = 4'd4
) (
  input logic               clk,
  input logic               rst,
  decode_writeback_if.slave bus
);

  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  // cc bit order is {OF,ZF,SF}; reset leaves ZF set
  localparam logic [2:0] CC_RESET = 3'b010;

  logic [63:0] regs_q [NREGS];
  logic [63:0] regs_d [NREGS];
  logic [2:0]  cc_q;
  logic [2:0]  cc_d;

  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic        cnd;
  logic        cc_of;
  logic        cc_zf;
  logic        cc_sf;
  logic        lt;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic [63:0] dbg_val;

  assign cc_of = cc_q[2];
  assign cc_zf = cc_q[1];
  assign cc_sf = cc_q[0];
  assign lt    = cc_sf ^ cc_of;

  // Source register selection from the instruction class
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (bus.icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.rA;
      I_RET, I_POPQ:                     src_a = RSP_ID;
      default:                           src_a = RNONE;
    endcase
    case (bus.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = bus.rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP_ID;
      default:                            src_b = RNONE;
    endcase
  end

  // Branch/move condition from the stored flags, never the incoming ones
  always_comb begin
    cnd = 1'b0;
    case (bus.ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt | cc_zf;
      4'd2:    cnd = lt;
      4'd3:    cnd = cc_zf;
      4'd4:    cnd = ~cc_zf;
      4'd5:    cnd = ~lt;
      4'd6:    cnd = ~lt & ~cc_zf;
      default: cnd = 1'b0;
    endcase
  end

  // Destination selection; a failed cmov suppresses its E write
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.icode)
      I_IRMOVQ, I_OPQ:                dst_e = bus.rB;
      I_RRMOVQ:                       dst_e = cnd ? bus.rB : RNONE;
      I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = RSP_ID;
      default:                        dst_e = RNONE;
    endcase
    case (bus.icode)
      I_MRMOVQ, I_POPQ: dst_m = bus.rA;
      default:          dst_m = RNONE;
    endcase
  end

  // Register reads: no write bypass, RNONE (or any id past the file) reads 0
  always_comb begin
    val_a   = '0;
    val_b   = '0;
    dbg_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_a == 4'(i))        val_a   = regs_q[i];
      if (src_b == 4'(i))        val_b   = regs_q[i];
      if (bus.dbg_addr == 4'(i)) dbg_val = regs_q[i];
    end
  end

  // Next register/CC state; M write applied after E so popq %rsp keeps valM
  always_comb begin
    cc_d = cc_q;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.wb_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (dst_e == 4'(i)) regs_d[i] = bus.valE;
        if (dst_m == 4'(i)) regs_d[i] = bus.valM;
      end
      if (bus.icode == I_OPQ) begin
        cc_d = {bus.OF, bus.ZF, bus.SF};
      end
    end
  end

  // State register with synchronous reset dominating any commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      cc_q <= CC_RESET;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cc_q <= cc_d;
    end
  end

  assign bus.valA     = val_a;
  assign bus.valB     = val_b;
  assign bus.Cnd      = cnd;
  assign bus.cc       = cc_q;
  assign bus.dstE     = dst_e;
  assign bus.dstM     = dst_m;
  assign bus.dbg_data = dbg_val;

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus randomized traffic.
// Reference model keeps the architectural register array and flags and applies the ISA rules directly.
module tb_decode_writeback;

  logic clk;
  logic rst;
  decode_writeback_if bus();

  decode_writeback #(.NREGS(15), .RSP_ID(4'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [15];
  logic [2:0]  m_cc;

  // ---------------- reference model ----------------
  function automatic logic [3:0] f_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return ra;
    if (ic inside {4'd9, 4'd11}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'd4, 4'd5, 4'd6}) return rb;
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic f_cnd(input logic [3:0] fn, input logic [2:0] c);
    logic of, zf, sf;
    of = c[2]; zf = c[1]; sf = c[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (sf ^ of) | zf;
      4'd2: return sf ^ of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !(sf ^ of);
      4'd6: return !(sf ^ of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_dst_e(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [3:0] rb, input logic [2:0] c);
    if (ic == 4'd3 || ic == 4'd6) return rb;
    if (ic == 4'd2) return f_cnd(fn, c) ? rb : 4'hF;
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (ic == 4'd5 || ic == 4'd11) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] f_read(input logic [3:0] id);
    if (id >= 4'd15) return 64'd0;
    return m_regs[id];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [2:0] flags, input logic we);
    bus.icode = ic;
    bus.ifun  = fn;
    bus.rA    = ra;
    bus.rB    = rb;
    bus.valE  = ve;
    bus.valM  = vm;
    bus.OF    = flags[2];
    bus.ZF    = flags[1];
    bus.SF    = flags[0];
    bus.wb_en = we;
  endtask

  // Advance one edge and apply the same edge to the model
  task automatic tick();
    logic [3:0] e, m;
    logic r, we;
    logic [3:0] ic;
    logic [63:0] ve, vm;
    logic [2:0] fl;
    e  = f_dst_e(bus.icode, bus.ifun, bus.rB, m_cc);
    m  = f_dst_m(bus.icode, bus.rA);
    r  = rst;
    we = bus.wb_en;
    ic = bus.icode;
    ve = bus.valE;
    vm = bus.valM;
    fl = {bus.OF, bus.ZF, bus.SF};
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_cc = 3'b010;
    end else if (we) begin
      if (e != 4'hF) m_regs[e] = ve;
      if (m != 4'hF) m_regs[m] = vm;
      if (ic == 4'd6) m_cc = fl;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(4'd0, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0, 3'b000, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #0.25;
      checks++;
      if (bus.dbg_data !== 64'd0) begin
        errors++;
        $display("FAIL reset_reg%0d got %h want 0", i, bus.dbg_data);
      end
    end
    checks++;
    if (bus.cc !== 3'b010) begin
      errors++;
      $display("FAIL reset_cc got %b want 010", bus.cc);
    end
    drive(4'd7, 4'd3, 4'hF, 4'hF, 64'd0, 64'd0, 3'b000, 1'b0);
    #1;
    checks++;
    if (bus.Cnd !== 1'b1) begin
      errors++;
      $display("FAIL reset_cnd_e got %b want 1", bus.Cnd);
    end
  endtask

  task automatic test_irmovq();
    drive(4'd3, 4'd0, 4'hF, 4'd2, 64'd7, 64'd0, 3'b000, 1'b1);
    #1;
    checks++;
    if (bus.dstE !== 4'd2) begin
      errors++;
      $display("FAIL irmovq_dstE got %h want 2", bus.dstE);
    end
    tick();
    bus.dbg_addr = 4'd2;
    #1;
    checks++;
    if (bus.dbg_data !== 64'd7) begin
      errors++;
      $display("FAIL irmovq_write got %0d want 7", bus.dbg_data);
    end
    drive(4'd3, 4'd0, 4'hF, 4'd2, 64'd9, 64'd0, 3'b000, 1'b0);
    tick();
    #1;
    checks++;
    if (bus.dbg_data !== 64'd7) begin
      errors++;
      $display("FAIL irmovq_wb_en0 got %0d want 7", bus.dbg_data);
    end
  endtask

  task automatic test_opq();
    drive(4'd3, 4'd0, 4'hF, 4'd3, 64'd5, 64'd0, 3'b000, 1'b1);
    tick();
    drive(4'd6, 4'd0, 4'd2, 4'd3, 64'd12, 64'd0, 3'b000, 1'b1);
    #1;
    checks++;
    if (bus.valA !== 64'd7) begin
      errors++;
      $display("FAIL opq_valA got %0d want 7", bus.valA);
    end
    checks++;
    if (bus.valB !== 64'd5) begin
      errors++;
      $display("FAIL opq_valB got %0d want 5", bus.valB);
    end
    tick();
    bus.dbg_addr = 4'd3;
    #1;
    checks++;
    if (bus.dbg_data !== 64'd12) begin
      errors++;
      $display("FAIL opq_write got %0d want 12", bus.dbg_data);
    end
    checks++;
    if (bus.cc !== 3'b000) begin
      errors++;
      $display("FAIL opq_cc got %b want 000", bus.cc);
    end
    drive(4'd7, 4'd6, 4'hF, 4'hF, 64'd0, 64'd0, 3'b111, 1'b0);
    #1;
    checks++;
    if (bus.Cnd !== 1'b1) begin
      errors++;
      $display("FAIL opq_cnd_g got %b want 1", bus.Cnd);
    end
  endtask

  task automatic test_cmov();
    logic [63:0] old5;
    drive(4'd6, 4'd0, 4'd2, 4'd6, 64'd1, 64'd0, 3'b001, 1'b1);
    tick();
    checks++;
    if (bus.cc !== 3'b001) begin
      errors++;
      $display("FAIL cmov_cc got %b want 001", bus.cc);
    end
    old5 = m_regs[5];
    drive(4'd2, 4'd3, 4'd2, 4'd5, 64'd9, 64'd0, 3'b000, 1'b1);
    #1;
    checks++;
    if (bus.dstE !== 4'hF) begin
      errors++;
      $display("FAIL cmove_dstE got %h want f", bus.dstE);
    end
    tick();
    bus.dbg_addr = 4'd5;
    #1;
    checks++;
    if (bus.dbg_data !== old5) begin
      errors++;
      $display("FAIL cmove_noreg got %0d want %0d", bus.dbg_data, old5);
    end
    drive(4'd2, 4'd2, 4'd2, 4'd5, 64'd9, 64'd0, 3'b000, 1'b1);
    #1;
    checks++;
    if (bus.dstE !== 4'd5) begin
      errors++;
      $display("FAIL cmovl_dstE got %h want 5", bus.dstE);
    end
    tick();
    #1;
    checks++;
    if (bus.dbg_data !== 64'd9) begin
      errors++;
      $display("FAIL cmovl_write got %0d want 9", bus.dbg_data);
    end
  endtask

  task automatic test_popq_rsp();
    drive(4'd3, 4'd0, 4'hF, 4'd4, 64'd100, 64'd0, 3'b000, 1'b1);
    tick();
    drive(4'd11, 4'd0, 4'd4, 4'hF, 64'd108, 64'd55, 3'b000, 1'b1);
    #1;
    checks++;
    if (bus.valA !== 64'd100 || bus.valB !== 64'd100) begin
      errors++;
      $display("FAIL popq_reads got %0d/%0d want 100/100", bus.valA, bus.valB);
    end
    checks++;
    if (bus.dstE !== 4'd4 || bus.dstM !== 4'd4) begin
      errors++;
      $display("FAIL popq_dst got %h/%h want 4/4", bus.dstE, bus.dstM);
    end
    tick();
    bus.dbg_addr = 4'd4;
    #1;
    checks++;
    if (bus.dbg_data !== 64'd55) begin
      errors++;
      $display("FAIL popq_valM_wins got %0d want 55", bus.dbg_data);
    end
  endtask

  task automatic test_reset_mid_write();
    drive(4'd3, 4'd0, 4'hF, 4'd1, 64'd33, 64'd0, 3'b000, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wb_en = 1'b0;
    bus.dbg_addr = 4'd1;
    #1;
    checks++;
    if (bus.dbg_data !== 64'd0) begin
      errors++;
      $display("FAIL midreset_reg1 got %0d want 0", bus.dbg_data);
    end
    checks++;
    if (bus.cc !== 3'b010) begin
      errors++;
      $display("FAIL midreset_cc got %b want 010", bus.cc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ic, fn, ra, rb, ad;
      ic = 4'($urandom_range(0, 15));
      fn = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      drive(ic, fn, ra, rb, {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      rst = ($urandom_range(0, 39) == 0);
      #1;
      checks++;
      if (bus.valA !== f_read(f_src_a(ic, ra))) begin
        errors++;
        $display("FAIL rnd_valA it%0d icode %0d got %h want %h", n, ic, bus.valA, f_read(f_src_a(ic, ra)));
      end
      checks++;
      if (bus.valB !== f_read(f_src_b(ic, rb))) begin
        errors++;
        $display("FAIL rnd_valB it%0d icode %0d got %h want %h", n, ic, bus.valB, f_read(f_src_b(ic, rb)));
      end
      checks++;
      if (bus.Cnd !== f_cnd(fn, m_cc)) begin
        errors++;
        $display("FAIL rnd_cnd it%0d ifun %0d got %b want %b", n, fn, bus.Cnd, f_cnd(fn, m_cc));
      end
      checks++;
      if (bus.dstE !== f_dst_e(ic, fn, rb, m_cc) || bus.dstM !== f_dst_m(ic, ra)) begin
        errors++;
        $display("FAIL rnd_dst it%0d got %h/%h want %h/%h", n, bus.dstE, bus.dstM,
                 f_dst_e(ic, fn, rb, m_cc), f_dst_m(ic, ra));
      end
      tick();
      rst = 1'b0;
      ad = 4'($urandom_range(0, 15));
      bus.dbg_addr = ad;
      #1;
      checks++;
      if (bus.dbg_data !== f_read(ad)) begin
        errors++;
        $display("FAIL rnd_reg it%0d addr %0d got %h want %h", n, ad, bus.dbg_data, f_read(ad));
      end
      checks++;
      if (bus.cc !== m_cc) begin
        errors++;
        $display("FAIL rnd_cc it%0d got %b want %b", n, bus.cc, m_cc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.dbg_addr = 4'd0;
    drive(4'd0, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0, 3'b000, 1'b0);
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_cc = 3'b010;
    #2;
    test_reset();
    test_irmovq();
    test_opq();
    test_cmov();
    test_popq_rsp();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 SEQ register file plus condition-code register, bundled with decode and writeback control.
- Supplies valA/valB to the execute stage, then retires execute's valE and memory's valM into the registers on the clock edge.
- Latches execute's OF/ZF/SF for OPq and evaluates Cnd for cmovXX/jXX.
- Sits between fetch (icode/ifun/rA/rB) and execute/memory.

Parameters:
- NREGS, 15, number of architectural registers (IDs 0..14); ID 4'hF = RNONE.
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- wb_en  in  1  commit enable; when 0, no register or CC update at the edge.
- icode  in  4  instruction code from fetch.
- ifun  in  4  function code from fetch.
- rA  in  4  register field A.
- rB  in  4  register field B.
- valE  in  64  execute result.
- valM  in  64  memory read data.
- OF  in  1  overflow flag from execute.
- ZF  in  1  zero flag from execute.
- SF  in  1  sign flag from execute.
- valA  out  64  decode read A (combinational).
- valB  out  64  decode read B (combinational).
- Cnd  out  1  condition result from the stored CC.
- cc  out  3  stored flags {OF,ZF,SF}.
- dstE  out  4  E write destination (debug).
- dstM  out  4  M write destination (debug).
- dbg_addr  in  4  debug read address.
- dbg_data  out  64  register[dbg_addr], 0 if dbg_addr >= 15.

Behaviour:
- Reset (rst=1 at posedge): all 15 registers <= 0; cc <= {OF=0,ZF=1,SF=0}. Reset overrides wb_en. Mid-program reset discards that cycle's writes.
- srcA: rA for icode 2,4,6,10; RSP_ID for 9,11; else RNONE.
- srcB: rB for icode 4,5,6; RSP_ID for 8,9,10,11; else RNONE.
- valA/valB: combinational reads of the current register contents; 0 when src is RNONE. No write bypass: a read in the same cycle as a write returns the old value.
- Cnd: evaluated combinationally from the stored cc (not the incoming flags).
  - ifun 0: 1
  - ifun 1 le: (SF^OF)|ZF
  - ifun 2 l: SF^OF
  - ifun 3 e: ZF
  - ifun 4 ne: !ZF
  - ifun 5 ge: !(SF^OF)
  - ifun 6 g: !(SF^OF)&!ZF
  - ifun >6: 0
- dstE:
  - rB for icode 3 and 6.
  - rB for icode 2 only when Cnd=1; RNONE when Cnd=0.
  - RSP_ID for icode 8,9,10,11.
  - Else RNONE.
- dstM: rA for icode 5,11; else RNONE.
- Writeback at posedge when wb_en=1 and rst=0:
  - reg[dstE] <= valE if dstE != RNONE.
  - reg[dstM] <= valM if dstM != RNONE.
  - If dstE == dstM (popq %rsp), valM wins.
- CC update: when icode=6 and wb_en=1, cc <= {OF,ZF,SF} at posedge. No other icode modifies cc.
- Halt/nop/invalid (icode 0, 1, >11): no register write, no CC update; valA=valB=0.
- Latency: reads and Cnd 0 cycles; writes and CC visible the cycle after the edge.

Test Plan:
- Reset then read all: rst=1 for one edge -> every dbg_data=0; cc=3'b010; Cnd=1 for ifun 3 (ZF=1).
- irmovq: icode=3, rB=2, valE=7, wb_en=1 -> after edge reg[2]=7. With wb_en=0 and valE=9 -> reg[2] stays 7.
- OPq then read: icode=6, rA=2 (7), rB=3 (5) -> valA=7, valB=5 before edge. valE=12, OF=0, ZF=0, SF=0 -> reg[3]=12, cc=000; then ifun 6 (g) -> Cnd=1.
- Conditional move: cc set to SF=1 via OPq; icode=2, ifun=3 (e), rB=5, valE=9 -> dstE=F, reg[5] unchanged. ifun=2 (l) -> reg[5]=9.
- popq %rsp conflict: reg[4]=100, icode=11, rA=4, valE=108, valM=55 -> srcA=srcB=4, valA=valB=100; after edge reg[4]=55.
- Reset mid-write: icode=3, rB=1, valE=33, wb_en=1, rst=1 same edge -> reg[1]=0, cc=010.
